csr_seq: RTL and testbench
==========================

Name: csr_seq

Overview:
Initiator-side sequencer that drives the single-write-port / single-read-port CSR register file. Executes Zicsr read-modify-write ops plus ECALL trap entry and MRET return. Because the CSR file has only one write port, multi-register updates are serialized.
Sits between the decode/execute stage (request/response handshake) and the CSR file (rd_reg/rd_bus, wr_en/wr_reg/wr_bus).

Parameters:
XLEN, 32, data width of CSRs, PC and operands
ECALL_CAUSE, 11, mcause value written on ECALL (environment call from M-mode)

Ports:
clk  in  1  clock; the CSR file write clock is tied to this
rst  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  high only in IDLE; a request is accepted when req_valid && req_ready
req_op  in  3  0=CSRRW 1=CSRRS 2=CSRRC 3=ECALL 4=MRET; 5-7 reserved, treated as no-op
req_addr  in  12  CSR address for ops 0-2
req_src  in  XLEN  rs1 value or zero-extended uimm
req_src_zero  in  1  rs1/uimm field is x0/0; suppresses the write for CSRRS/CSRRC
req_pc  in  XLEN  PC of the instruction
resp_valid  out  1  one-cycle completion pulse; no backpressure
resp_rdata  out  XLEN  old CSR value for ops 0-2, else 0
resp_redirect  out  1  high with resp_valid for ECALL/MRET
resp_pc  out  XLEN  redirect target
csr_rd_reg  out  12  to CSR file read address
csr_rd_bus  in  XLEN  combinational read data from CSR file
csr_wr_en  out  1  CSR write enable
csr_wr_reg  out  12  CSR write address
csr_wr_bus  out  XLEN  CSR write data

Behaviour:
- Reset: state=IDLE; req_ready=1; resp_valid, resp_redirect, csr_wr_en=0; resp_rdata, resp_pc, csr_rd_reg, csr_wr_reg, csr_wr_bus=0. Reset mid-sequence aborts to IDLE. No write is issued in the reset cycle. Partially applied trap writes are not undone.
- Acceptance cycle: op, addr, src, src_zero and pc are latched; next state is chosen from op.
- Outside its assigned states, csr_wr_en=0 and csr_rd_reg=0.
- S_CSR (ops 0-2), one cycle:
  - csr_rd_reg=addr; old=csr_rd_bus, latched into resp_rdata.
  - new value: RW: src. RS: old|src. RC: old&~src.
  - csr_wr_en=1 except RS/RC with src_zero.
  - csr_wr_reg=addr, csr_wr_bus=new.
  - Next: S_RESP.
- ECALL sequence, one cycle each:
  - S_EPC: write 0x341 <= pc.
  - S_CAUSE: write 0x342 <= ECALL_CAUSE.
  - S_TSTAT: read 0x300, write 0x300 <= old with MPIE(bit7)=old MIE(bit3), MIE=0, MPP[12:11]=2'b11.
  - S_VEC: read 0x305; target={rd[31:2],2'b00}.
  - Then S_RESP.
- MRET sequence:
  - S_RSTAT: read 0x300, write 0x300 <= old with MIE=old MPIE, MPIE=1, MPP=2'b11 (M-only core).
  - S_EPCRD: read 0x341; target=rd.
  - Then S_RESP.
- Reserved op: go straight to S_RESP; redirect=0, rdata=0, no CSR access.
- S_RESP: resp_valid=1 for exactly one cycle; next state IDLE.
- Latency from acceptance edge to resp_valid: CSR ops 2 cycles, ECALL 5, MRET 3, reserved 1.
- req_ready=0 in every state except IDLE, so the minimum request spacing is latency+1.
- Reads are combinational and writes commit at the clk edge. A read and a write to the same CSR in the same state therefore see the pre-write value.
- Unknown CSR addresses are passed through unchecked; the CSR file reads 0 and ignores the write.

Decomposition:
- Shared package csr_pkg:
  - op encodings
  - CSR addresses: MSTATUS 0x300, MTVEC 0x305, MEPC 0x341, MCAUSE 0x342
  - mstatus bit positions (MIE=3, MPIE=7, MPP=12:11)
  - state enum
- One combinational sub-module, csr_wdata_calc (op, old, src -> new, wr_suppress), reused by S_CSR.

Test Plan:
- Reset, then CSRRW addr 0x305 src 0x80000100 with mtvec=0 -> resp_valid 2 cycles after acceptance; rdata=0; mtvec=0x80000100.
- mstatus=0x1800, CSRRS 0x300 src 0x8 -> rdata 0x1800, mstatus=0x1808. Then CSRRC 0x300 src 0x8 with src_zero=1 -> rdata 0x1808, csr_wr_en never asserted.
- mstatus=0x1808, mtvec=0x80000103, ECALL pc 0x80000040 -> writes in order mepc=0x80000040, mcause=11, mstatus=0x1880. resp_valid at cycle 5 with redirect=1, pc=0x80000100.
- Following the previous case, MRET -> mstatus=0x1888; resp at cycle 3 with redirect=1, pc=0x80000040.
- ECALL, then rst asserted in the S_CAUSE cycle -> mcause unchanged, no resp_valid, req_ready=1 the cycle after reset. A new CSRRW completes normally.
- req_valid held high continuously with CSRRW ops -> acceptances spaced 3 cycles apart; req_ready=0 while busy; each request executes exactly once.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared encodings for the CSR sequencer: op codes, machine CSR addresses,
// mstatus bit positions and the sequencer state enum.
// No ports; imported by csr_seq and csr_wdata_calc.
package csr_pkg;

  localparam logic [2:0] OP_CSRRW = 3'd0;
  localparam logic [2:0] OP_CSRRS = 3'd1;
  localparam logic [2:0] OP_CSRRC = 3'd2;
  localparam logic [2:0] OP_ECALL = 3'd3;
  localparam logic [2:0] OP_MRET  = 3'd4;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CSR,
    S_EPC,
    S_CAUSE,
    S_TSTAT,
    S_VEC,
    S_RSTAT,
    S_EPCRD,
    S_RESP
  } state_e;

endpackage

// File: rtl/csr_wdata_calc.sv
// Purpose: new CSR value for CSRRW/CSRRS/CSRRC and the write-suppress flag.
// Latency: purely combinational. Backpressure: none.
// Ports: op_i (op code), old_i (current CSR value), src_i (rs1/uimm),
//        src_zero_i (rs1/uimm is x0/0), new_o (value to write), wr_suppress_o.
module csr_wdata_calc
  import csr_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] old_i,
  input  logic [XLEN-1:0] src_i,
  input  logic            src_zero_i,
  output logic [XLEN-1:0] new_o,
  output logic            wr_suppress_o
);

  always_comb begin
    new_o         = src_i;
    wr_suppress_o = 1'b0;
    case (op_i)
      OP_CSRRW: new_o = src_i;
      OP_CSRRS: begin
        new_o         = old_i | src_i;
        wr_suppress_o = src_zero_i;
      end
      OP_CSRRC: begin
        new_o         = old_i & ~src_i;
        wr_suppress_o = src_zero_i;
      end
      default: new_o = src_i;
    endcase
  end

endmodule

// File: rtl/csr_seq.sv
// Purpose: sequences Zicsr RMW ops, ECALL trap entry and MRET through a
//          one-read/one-write-port CSR file, one CSR write per cycle.
// Latency: accept->resp_valid CSR 2, ECALL 5, MRET 3, reserved 1; req_ready only in IDLE.
// Ports: req_* / resp_* handshake to decode/execute; csr_rd_* combinational
//        read port and csr_wr_* write port (commits at clk edge) to the CSR file.
module csr_seq
  import csr_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int ECALL_CAUSE = 11
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [11:0]     req_addr,
  input  logic [XLEN-1:0] req_src,
  input  logic            req_src_zero,
  input  logic [XLEN-1:0] req_pc,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_redirect,
  output logic [XLEN-1:0] resp_pc,
  output logic [11:0]     csr_rd_reg,
  input  logic [XLEN-1:0] csr_rd_bus,
  output logic            csr_wr_en,
  output logic [11:0]     csr_wr_reg,
  output logic [XLEN-1:0] csr_wr_bus
);

  state_e          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [11:0]     addr_q, addr_d;
  logic [XLEN-1:0] src_q, src_d;
  logic            src_zero_q, src_zero_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic [XLEN-1:0] tgt_q, tgt_d;
  logic            redir_q, redir_d;

  logic [XLEN-1:0] calc_new;
  logic            calc_suppress;
  logic [XLEN-1:0] stat_trap;
  logic [XLEN-1:0] stat_ret;

  csr_wdata_calc #(.XLEN(XLEN)) u_wdata_calc (
    .op_i          (op_q),
    .old_i         (csr_rd_bus),
    .src_i         (src_q),
    .src_zero_i    (src_zero_q),
    .new_o         (calc_new),
    .wr_suppress_o (calc_suppress)
  );

  // mstatus images for trap entry and return, built from the live read data.
  always_comb begin
    stat_trap                               = csr_rd_bus;
    stat_trap[MSTATUS_MPIE]                 = csr_rd_bus[MSTATUS_MIE];
    stat_trap[MSTATUS_MIE]                  = 1'b0;
    stat_trap[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;

    stat_ret                                = csr_rd_bus;
    stat_ret[MSTATUS_MIE]                   = csr_rd_bus[MSTATUS_MPIE];
    stat_ret[MSTATUS_MPIE]                  = 1'b1;
    stat_ret[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      addr_q     <= '0;
      src_q      <= '0;
      src_zero_q <= 1'b0;
      pc_q       <= '0;
      rdata_q    <= '0;
      tgt_q      <= '0;
      redir_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      src_q      <= src_d;
      src_zero_q <= src_zero_d;
      pc_q       <= pc_d;
      rdata_q    <= rdata_d;
      tgt_q      <= tgt_d;
      redir_q    <= redir_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    src_d      = src_q;
    src_zero_d = src_zero_q;
    pc_d       = pc_q;
    rdata_d    = rdata_q;
    tgt_d      = tgt_q;
    redir_d    = redir_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    csr_rd_reg = '0;
    csr_wr_en  = 1'b0;
    csr_wr_reg = '0;
    csr_wr_bus = '0;

    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          op_d       = req_op;
          addr_d     = req_addr;
          src_d      = req_src;
          src_zero_d = req_src_zero;
          pc_d       = req_pc;
          // Clear response fields so ops that do not produce them report 0.
          rdata_d    = '0;
          tgt_d      = '0;
          redir_d    = 1'b0;
          case (req_op)
            OP_CSRRW, OP_CSRRS, OP_CSRRC: state_d = S_CSR;
            OP_ECALL:                     state_d = S_EPC;
            OP_MRET:                      state_d = S_RSTAT;
            default:                      state_d = S_RESP;
          endcase
        end
      end
      S_CSR: begin
        csr_rd_reg = addr_q;
        rdata_d    = csr_rd_bus;
        csr_wr_en  = ~calc_suppress;
        csr_wr_reg = addr_q;
        csr_wr_bus = calc_new;
        state_d    = S_RESP;
      end
      S_EPC: begin
        csr_wr_en  = 1'b1;
        csr_wr_reg = CSR_MEPC;
        csr_wr_bus = pc_q;
        state_d    = S_CAUSE;
      end
      S_CAUSE: begin
        csr_wr_en  = 1'b1;
        csr_wr_reg = CSR_MCAUSE;
        csr_wr_bus = XLEN'(ECALL_CAUSE);
        state_d    = S_TSTAT;
      end
      S_TSTAT: begin
        csr_rd_reg = CSR_MSTATUS;
        csr_wr_en  = 1'b1;
        csr_wr_reg = CSR_MSTATUS;
        csr_wr_bus = stat_trap;
        state_d    = S_VEC;
      end
      S_VEC: begin
        csr_rd_reg = CSR_MTVEC;
        // Direct mode only: mode bits of mtvec are dropped.
        tgt_d      = {csr_rd_bus[XLEN-1:2], 2'b00};
        redir_d    = 1'b1;
        state_d    = S_RESP;
      end
      S_RSTAT: begin
        csr_rd_reg = CSR_MSTATUS;
        csr_wr_en  = 1'b1;
        csr_wr_reg = CSR_MSTATUS;
        csr_wr_bus = stat_ret;
        state_d    = S_EPCRD;
      end
      S_EPCRD: begin
        csr_rd_reg = CSR_MEPC;
        tgt_d      = csr_rd_bus;
        redir_d    = 1'b1;
        state_d    = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // The reset cycle must not commit a write or announce a response, even
    // when reset lands mid-sequence.
    if (rst) begin
      resp_valid = 1'b0;
      csr_rd_reg = '0;
      csr_wr_en  = 1'b0;
      csr_wr_reg = '0;
      csr_wr_bus = '0;
    end
  end

  assign resp_rdata    = rdata_q;
  assign resp_pc       = tgt_q;
  assign resp_redirect = resp_valid & redir_q;

endmodule

// File: tb/tb_csr_seq.sv
// Directed bench for csr_seq with a small behavioural CSR file (mstatus,
// mtvec, mepc, mcause) that logs every committed write.
module tb_csr_seq;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [11:0] req_addr;
  logic [31:0] req_src;
  logic        req_src_zero;
  logic [31:0] req_pc;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_redirect;
  logic [31:0] resp_pc;
  logic [11:0] csr_rd_reg;
  logic [31:0] csr_rd_bus;
  logic        csr_wr_en;
  logic [11:0] csr_wr_reg;
  logic [31:0] csr_wr_bus;

  int pass_cnt = 0;
  int total_cnt = 0;

  csr_seq #(.XLEN(32), .ECALL_CAUSE(11)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op        (req_op),
    .req_addr      (req_addr),
    .req_src       (req_src),
    .req_src_zero  (req_src_zero),
    .req_pc        (req_pc),
    .resp_valid    (resp_valid),
    .resp_rdata    (resp_rdata),
    .resp_redirect (resp_redirect),
    .resp_pc       (resp_pc),
    .csr_rd_reg    (csr_rd_reg),
    .csr_rd_bus    (csr_rd_bus),
    .csr_wr_en     (csr_wr_en),
    .csr_wr_reg    (csr_wr_reg),
    .csr_wr_bus    (csr_wr_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural CSR file: combinational read, write at posedge, preload port.
  logic [31:0] m_status, m_tvec, m_epc, m_cause;
  logic        pl_en;
  logic [11:0] pl_addr;
  logic [31:0] pl_dat;
  logic [11:0] wlog_a [64];
  logic [31:0] wlog_d [64];
  int          wcnt = 0;

  initial begin
    m_status = '0; m_tvec = '0; m_epc = '0; m_cause = '0;
  end

  always_comb begin
    case (csr_rd_reg)
      12'h300: csr_rd_bus = m_status;
      12'h305: csr_rd_bus = m_tvec;
      12'h341: csr_rd_bus = m_epc;
      12'h342: csr_rd_bus = m_cause;
      default: csr_rd_bus = '0;
    endcase
  end

  always @(posedge clk) begin
    if (pl_en) begin
      case (pl_addr)
        12'h300: m_status <= pl_dat;
        12'h305: m_tvec   <= pl_dat;
        12'h341: m_epc    <= pl_dat;
        12'h342: m_cause  <= pl_dat;
        default: ;
      endcase
    end else if (csr_wr_en) begin
      case (csr_wr_reg)
        12'h300: m_status <= csr_wr_bus;
        12'h305: m_tvec   <= csr_wr_bus;
        12'h341: m_epc    <= csr_wr_bus;
        12'h342: m_cause  <= csr_wr_bus;
        default: ;
      endcase
      if (wcnt < 64) begin
        wlog_a[wcnt] <= csr_wr_reg;
        wlog_d[wcnt] <= csr_wr_bus;
      end
      wcnt <= wcnt + 1;
    end
  end

  task automatic preload(input logic [11:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    pl_en = 1'b1; pl_addr = a; pl_dat = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // Issue one request, return latency (acceptance edge to resp_valid sample) and response.
  task automatic do_req(input logic [2:0] op, input logic [11:0] addr, input logic [31:0] src,
                        input logic zero, input logic [31:0] pc, output int lat,
                        output logic [31:0] rdata, output logic redir, output logic [31:0] rpc,
                        output int nwr);
    int w0;
    lat = -1; rdata = 32'hDEAD_BEEF; redir = 1'bx; rpc = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = op; req_addr = addr; req_src = src;
    req_src_zero = zero; req_pc = pc;
    w0 = wcnt;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) break;
    end
    @(posedge clk); #1;
    req_valid = 1'b0; req_src_zero = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = i; rdata = resp_rdata; redir = resp_redirect; rpc = resp_pc;
        break;
      end
    end
    @(posedge clk); #1;
    nwr = wcnt - w0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (req_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", req_ready); else pass_cnt++;
    total_cnt++;
    if ({resp_valid, resp_redirect, csr_wr_en} !== 3'b000)
      $display("FAIL reset_ctrl: got %b want 000", {resp_valid, resp_redirect, csr_wr_en});
    else pass_cnt++;
    total_cnt++;
    if ({resp_rdata, resp_pc, csr_wr_bus} !== 96'd0)
      $display("FAIL reset_data: got %h/%h/%h want 0", resp_rdata, resp_pc, csr_wr_bus);
    else pass_cnt++;
    total_cnt++;
    if ({csr_rd_reg, csr_wr_reg} !== 24'd0)
      $display("FAIL reset_regs: got %h/%h want 0", csr_rd_reg, csr_wr_reg);
    else pass_cnt++;
  endtask

  task automatic test_csrrw;
    int lat, nwr; logic [31:0] rd, rpc; logic rdr;
    preload(12'h305, 32'h0);
    do_req(3'd0, 12'h305, 32'h8000_0100, 1'b0, 32'h0, lat, rd, rdr, rpc, nwr);
    total_cnt++;
    if (lat !== 2) $display("FAIL rw_lat: got %0d want 2", lat); else pass_cnt++;
    total_cnt++;
    if (rd !== 32'h0 || rdr !== 1'b0) $display("FAIL rw_resp: got %h/%b want 0/0", rd, rdr); else pass_cnt++;
    total_cnt++;
    if (m_tvec !== 32'h8000_0100 || nwr !== 1)
      $display("FAIL rw_write: got mtvec %h writes %0d want 80000100/1", m_tvec, nwr);
    else pass_cnt++;
  endtask

  task automatic test_rs_rc;
    int lat, nwr; logic [31:0] rd, rpc; logic rdr;
    preload(12'h300, 32'h1800);
    do_req(3'd1, 12'h300, 32'h8, 1'b0, 32'h0, lat, rd, rdr, rpc, nwr);
    total_cnt++;
    if (lat !== 2 || rd !== 32'h1800) $display("FAIL rs_resp: got lat %0d rdata %h want 2/1800", lat, rd); else pass_cnt++;
    total_cnt++;
    if (m_status !== 32'h1808 || nwr !== 1)
      $display("FAIL rs_write: got %h writes %0d want 1808/1", m_status, nwr);
    else pass_cnt++;
    do_req(3'd2, 12'h300, 32'h8, 1'b1, 32'h0, lat, rd, rdr, rpc, nwr);
    total_cnt++;
    if (lat !== 2 || rd !== 32'h1808) $display("FAIL rc_zero_resp: got lat %0d rdata %h want 2/1808", lat, rd); else pass_cnt++;
    total_cnt++;
    if (m_status !== 32'h1808 || nwr !== 0)
      $display("FAIL rc_zero_nowrite: got %h writes %0d want 1808/0", m_status, nwr);
    else pass_cnt++;
  endtask

  task automatic test_reserved;
    int lat, nwr; logic [31:0] rd, rpc; logic rdr;
    do_req(3'd5, 12'h300, 32'hFFFF_FFFF, 1'b0, 32'h1234, lat, rd, rdr, rpc, nwr);
    total_cnt++;
    if (lat !== 1) $display("FAIL rsvd_lat: got %0d want 1", lat); else pass_cnt++;
    total_cnt++;
    if (rd !== 32'h0 || rdr !== 1'b0 || nwr !== 0)
      $display("FAIL rsvd_resp: got rdata %h redir %b writes %0d want 0/0/0", rd, rdr, nwr);
    else pass_cnt++;
  endtask

  task automatic test_ecall;
    int lat, nwr, w0; logic [31:0] rd, rpc; logic rdr;
    preload(12'h305, 32'h8000_0103);
    w0 = wcnt;
    do_req(3'd3, 12'h000, 32'h0, 1'b0, 32'h8000_0040, lat, rd, rdr, rpc, nwr);
    total_cnt++;
    if (lat !== 5) $display("FAIL ecall_lat: got %0d want 5", lat); else pass_cnt++;
    total_cnt++;
    if (rdr !== 1'b1 || rpc !== 32'h8000_0100 || rd !== 32'h0)
      $display("FAIL ecall_resp: got redir %b pc %h rdata %h want 1/80000100/0", rdr, rpc, rd);
    else pass_cnt++;
    total_cnt++;
    if (nwr !== 3) $display("FAIL ecall_nwr: got %0d want 3", nwr); else pass_cnt++;
    total_cnt++;
    if (wlog_a[w0] !== 12'h341 || wlog_d[w0] !== 32'h8000_0040)
      $display("FAIL ecall_w0: got %h<=%h want 341<=80000040", wlog_a[w0], wlog_d[w0]);
    else pass_cnt++;
    total_cnt++;
    if (wlog_a[w0+1] !== 12'h342 || wlog_d[w0+1] !== 32'd11)
      $display("FAIL ecall_w1: got %h<=%h want 342<=b", wlog_a[w0+1], wlog_d[w0+1]);
    else pass_cnt++;
    total_cnt++;
    if (wlog_a[w0+2] !== 12'h300 || wlog_d[w0+2] !== 32'h1880)
      $display("FAIL ecall_w2: got %h<=%h want 300<=1880", wlog_a[w0+2], wlog_d[w0+2]);
    else pass_cnt++;
  endtask

  task automatic test_mret;
    int lat, nwr; logic [31:0] rd, rpc; logic rdr;
    do_req(3'd4, 12'h000, 32'h0, 1'b0, 32'h0, lat, rd, rdr, rpc, nwr);
    total_cnt++;
    if (lat !== 3) $display("FAIL mret_lat: got %0d want 3", lat); else pass_cnt++;
    total_cnt++;
    if (rdr !== 1'b1 || rpc !== 32'h8000_0040)
      $display("FAIL mret_resp: got redir %b pc %h want 1/80000040", rdr, rpc);
    else pass_cnt++;
    total_cnt++;
    if (m_status !== 32'h1888 || nwr !== 1)
      $display("FAIL mret_stat: got %h writes %0d want 1888/1", m_status, nwr);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    int lat, nwr, seen; logic [31:0] rd, rpc; logic rdr;
    preload(12'h342, 32'h5A);
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = 3'd3; req_pc = 32'h8000_0200;
    @(negedge clk);
    @(posedge clk); #1;             // acceptance edge, now in S_EPC
    req_valid = 1'b0;
    @(posedge clk); #1;             // now in S_CAUSE
    rst = 1'b1;
    seen = 0;
    @(negedge clk);
    if (resp_valid) seen++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (req_ready !== 1'b1) $display("FAIL midrst_ready: got %b want 1", req_ready); else pass_cnt++;
    total_cnt++;
    if (m_cause !== 32'h5A) $display("FAIL midrst_mcause: got %h want 5a", m_cause); else pass_cnt++;
    for (int i = 0; i < 6; i++) begin
      if (resp_valid) seen++;
      @(negedge clk);
    end
    total_cnt++;
    if (seen !== 0) $display("FAIL midrst_noresp: got %0d pulses want 0", seen); else pass_cnt++;
    do_req(3'd0, 12'h342, 32'h7, 1'b0, 32'h0, lat, rd, rdr, rpc, nwr);
    total_cnt++;
    if (lat !== 2 || rd !== 32'h5A || m_cause !== 32'h7)
      $display("FAIL midrst_after: got lat %0d rdata %h mcause %h want 2/5a/7", lat, rd, m_cause);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    logic [31:0] vals [3];
    logic [31:0] exp_rd [3];
    int n_acc, n_resp, last, w0;
    vals[0] = 32'hA0A0_0001; vals[1] = 32'hB0B0_0002; vals[2] = 32'hC0C0_0003;
    exp_rd[0] = 32'h11; exp_rd[1] = vals[0]; exp_rd[2] = vals[1];
    preload(12'h341, 32'h11);
    @(posedge clk); #1;
    w0 = wcnt;
    req_valid = 1'b1; req_op = 3'd0; req_addr = 12'h341; req_src = vals[0]; req_src_zero = 1'b0;
    n_acc = 0; n_resp = 0; last = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        total_cnt++;
        if (n_resp < 3 && resp_rdata !== exp_rd[n_resp])
          $display("FAIL b2b_rdata%0d: got %h want %h", n_resp, resp_rdata, exp_rd[n_resp]);
        else pass_cnt++;
        n_resp++;
      end
      if (req_valid && req_ready) begin
        if (n_acc > 0) begin
          total_cnt++;
          if (c - last !== 3) $display("FAIL b2b_spacing: got %0d want 3", c - last); else pass_cnt++;
        end
        last = c;
        n_acc++;
        @(posedge clk); #1;
        if (n_acc < 3) req_src = vals[n_acc]; else req_valid = 1'b0;
      end
      if (n_resp >= 3) break;
    end
    @(posedge clk); #1;
    total_cnt++;
    if (n_acc !== 3 || n_resp !== 3)
      $display("FAIL b2b_count: got acc %0d resp %0d want 3/3", n_acc, n_resp);
    else pass_cnt++;
    total_cnt++;
    if (m_epc !== vals[2] || wcnt - w0 !== 3)
      $display("FAIL b2b_final: got mepc %h writes %0d want c0c00003/3", m_epc, wcnt - w0);
    else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_addr = '0; req_src = '0;
    req_src_zero = 1'b0; req_pc = '0;
    pl_en = 1'b0; pl_addr = '0; pl_dat = '0;
    test_reset();
    test_csrrw();
    test_rs_rc();
    test_reserved();
    test_ecall();
    test_mret();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
